// File: rtl/rx_window_sched_if.sv
// ----------------------------------------------------------------------------
// rx_window_sched_if
// Bundle of the requester and radio-side signals of the receive-window
// scheduler.
//   master : the requesters' side (drives req/len/abort, observes the rest)
//   slave  : the scheduler's side
// Signals:
//   req[NREQ]       per-requester level request, held until its grant
//   len[NREQ*LW]    per-requester window length, field i = len[i*LW +: LW]
//   abort           end the current window early
//   gnt[NREQ]       one-hot, one-cycle grant pulse
//   owner           index of the current or last granted requester
//   radio_rx_en     raw radio receive enable (to the synchronizer)
//   rx_window       received data valid
//   done / aborted  end-of-window pulse and its qualifier
//   busy            scheduler not idle
// ----------------------------------------------------------------------------
interface rx_window_sched_if #(
    parameter int NREQ = 4,
    parameter int LW   = 8
) ();
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*LW-1:0] len;
    logic               abort;
    logic [NREQ-1:0]    gnt;
    logic [OW-1:0]      owner;
    logic               radio_rx_en;
    logic               rx_window;
    logic               done;
    logic               aborted;
    logic               busy;

    modport master (
        output req, len, abort,
        input  gnt, owner, radio_rx_en, rx_window, done, aborted, busy
    );

    modport slave (
        input  req, len, abort,
        output gnt, owner, radio_rx_en, rx_window, done, aborted, busy
    );
endinterface

// File: rtl/rx_window_sched.sv
// ----------------------------------------------------------------------------
// rx_window_sched
// Round-robin receive-window scheduler. Picks one of NREQ requesters, then
// drives the raw radio enable through WARMUP (WARMUP_CYC cycles), ACTIVE
// (latched len cycles, data valid) and GUARD (GUARD_CYC cycles, radio off).
// Ports:
//   ck    clock, all logic on posedge
//   arst  asynchronous active-high reset
//   bus   rx_window_sched_if.slave (requests, lengths, abort, grant/status)
// All outputs are registered.
// ----------------------------------------------------------------------------
module rx_window_sched #(
    parameter int NREQ       = 4,
    parameter int LW         = 8,
    parameter int WARMUP_CYC = 4,
    parameter int GUARD_CYC  = 2
) (
    input  logic              ck,
    input  logic              arst,
    rx_window_sched_if.slave  bus
);
    localparam int OW     = $clog2(NREQ);
    localparam int MAX_WG = (WARMUP_CYC > GUARD_CYC) ? WARMUP_CYC : GUARD_CYC;
    localparam int CW_PH  = $clog2(MAX_WG) + 1;
    // Wide enough for any phase length; a full-scale len never wraps.
    localparam int CW     = (LW > CW_PH) ? LW : CW_PH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARMUP,
        S_ACTIVE,
        S_GUARD
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   len_q, len_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            radio_rx_en_q, radio_rx_en_d;
    logic            rx_window_q, rx_window_d;
    logic            done_q, done_d;
    logic            aborted_q, aborted_d;
    logic            busy_q, busy_d;

    // Per-requester length fields.
    logic [LW-1:0] len_arr [NREQ];
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
            assign len_arr[gi] = bus.len[gi*LW +: LW];
        end
    endgenerate

    // Round-robin pick: scan offsets from high to low so the last hit is the
    // one closest to rr_ptr (first set bit at or above rr_ptr, wrapping).
    logic          found;
    logic [OW-1:0] win_idx;
    logic [OW:0]   cand;

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr_q} + (OW+1)'(i);
            if (cand >= (OW+1)'(NREQ)) begin
                cand = cand - (OW+1)'(NREQ);
            end
            if (bus.req[cand[OW-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[OW-1:0];
            end
        end
    end

    logic cnt_last;
    assign cnt_last = (cnt_q == CW'(1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = '0;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d  = S_WARMUP;
                    cnt_d    = CW'(WARMUP_CYC);
                    len_d    = len_arr[win_idx];
                    owner_d  = win_idx;
                    rr_ptr_d = (win_idx == OW'(NREQ - 1)) ? '0 : win_idx + OW'(1);
                    gnt_d    = NREQ'(1) << win_idx;
                end
            end
            S_WARMUP: begin
                if (bus.abort) begin
                    state_d   = S_GUARD;
                    cnt_d     = CW'(GUARD_CYC);
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (cnt_last) begin
                    if (len_q != '0) begin
                        state_d = S_ACTIVE;
                        cnt_d   = CW'(len_q);
                    end else begin
                        // Zero-length window: straight to guard, radio never valid.
                        state_d = S_GUARD;
                        cnt_d   = CW'(GUARD_CYC);
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACTIVE: begin
                if (bus.abort) begin
                    state_d   = S_GUARD;
                    cnt_d     = CW'(GUARD_CYC);
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (cnt_last) begin
                    state_d = S_GUARD;
                    cnt_d   = CW'(GUARD_CYC);
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GUARD: begin
                if (cnt_last) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered copies of what the next state implies.
        radio_rx_en_d = (state_d == S_WARMUP) || (state_d == S_ACTIVE);
        rx_window_d   = (state_d == S_ACTIVE);
        busy_d        = (state_d != S_IDLE);
    end

    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            len_q         <= '0;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            gnt_q         <= '0;
            radio_rx_en_q <= 1'b0;
            rx_window_q   <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_q         <= gnt_d;
            radio_rx_en_q <= radio_rx_en_d;
            rx_window_q   <= rx_window_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.owner       = owner_q;
    assign bus.radio_rx_en = radio_rx_en_q;
    assign bus.rx_window   = rx_window_q;
    assign bus.done        = done_q;
    assign bus.aborted     = aborted_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_rx_window_sched.sv
// ----------------------------------------------------------------------------
// tb_rx_window_sched
// Scoreboard bench for rx_window_sched: each expected window profile is
// queued when its request is driven; a monitor measures every granted window
// (grant, owner, enable/valid cycle counts, done position, abort flag, busy
// length, grant spacing) and compares it against the queued entry when the
// scheduler returns to idle.
// ----------------------------------------------------------------------------
module tb_rx_window_sched;
    localparam int NREQ = 4;
    localparam int LW   = 8;
    localparam int W    = 4;
    localparam int G    = 2;

    typedef struct {
        logic [NREQ-1:0] gnt;
        int owner;
        int en;
        int win;
        int win_first;
        int dones;
        int done_off;
        int abt;
        int busy;
        int gap;
    } exp_t;

    logic ck;
    logic arst;

    rx_window_sched_if #(.NREQ(NREQ), .LW(LW)) bus ();

    rx_window_sched #(
        .NREQ(NREQ), .LW(LW), .WARMUP_CYC(W), .GUARD_CYC(G)
    ) dut (
        .ck   (ck),
        .arst (arst),
        .bus  (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int   n_vec = 0;
    int   n_mis = 0;
    exp_t sb[$];

    // Monitor state.
    bit              in_win = 1'b0;
    bit              have_last = 1'b0;
    int              cyc = 0;
    int              last_cyc = 0;
    int              t, r_en, r_win, r_wfirst, r_dones, r_doff, r_abt, r_busy, r_gap, r_owner;
    logic [NREQ-1:0] r_gnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input int owner, input int l, input int abort_t, input int gap);
        exp_t            e;
        logic [NREQ-1:0] one;
        one         = 1;
        e.gnt       = one << owner;
        e.owner     = owner;
        e.dones     = 1;
        e.gap       = gap;
        if (abort_t == 0) begin
            e.en        = W + l;
            e.win       = l;
            e.win_first = (l > 0) ? W + 1 : 0;
            e.done_off  = W + l + 1;
            e.abt       = 0;
            e.busy      = W + l + G;
        end else begin
            e.en        = abort_t;
            e.win       = (abort_t > W) ? abort_t - W : 0;
            e.win_first = (abort_t > W) ? W + 1 : 0;
            e.done_off  = abort_t + 1;
            e.abt       = 1;
            e.busy      = abort_t + G;
        end
        return e;
    endfunction

    task automatic finish_window();
        exp_t e;
        $display("window gnt=%b owner=%0d en=%0d win=%0d first=%0d done@%0d abt=%0d busy=%0d gap=%0d",
                 r_gnt, r_owner, r_en, r_win, r_wfirst, r_doff, r_abt, r_busy, r_gap);
        if (sb.size() == 0) begin
            chk("sb_underflow_gnt", r_gnt, 0);
        end else begin
            e = sb.pop_front();
            chk("gnt",       r_gnt,    e.gnt);
            chk("owner",     r_owner,  e.owner);
            chk("en_cycles", r_en,     e.en);
            chk("win_cycles",r_win,    e.win);
            chk("win_first", r_wfirst, e.win_first);
            chk("done_cnt",  r_dones,  e.dones);
            chk("done_off",  r_doff,   e.done_off);
            chk("aborted",   r_abt,    e.abt);
            chk("busy_len",  r_busy,   e.busy);
            if (e.gap >= 0) chk("gnt_gap", r_gap, e.gap);
        end
        in_win = 1'b0;
    endtask

    task automatic monitor();
        forever begin
            @(negedge ck);
            if (arst) begin
                in_win    = 1'b0;
                have_last = 1'b0;
            end else begin
                cyc++;
                if (bus.gnt != '0) begin
                    in_win    = 1'b1;
                    t         = 0;
                    r_gnt     = bus.gnt;
                    r_owner   = int'(bus.owner);
                    r_gap     = have_last ? cyc - last_cyc : -1;
                    last_cyc  = cyc;
                    have_last = 1'b1;
                    r_en = 0; r_win = 0; r_wfirst = 0; r_dones = 0;
                    r_doff = 0; r_abt = 0; r_busy = 0;
                end
                if (in_win) begin
                    t++;
                    if (bus.radio_rx_en) r_en++;
                    if (bus.rx_window) begin
                        if (r_win == 0) r_wfirst = t;
                        r_win++;
                    end
                    if (bus.done) begin
                        r_dones++;
                        r_doff = t;
                        r_abt  = int'(bus.aborted);
                    end
                    if (bus.busy) r_busy++;
                    else finish_window();
                end
            end
        end
    endtask

    task automatic set_len(input int i, input int v);
        bus.len[i*LW +: LW] = LW'(v);
    endtask

    task automatic chk_outs_zero();
        chk("rst_gnt",     bus.gnt,         0);
        chk("rst_owner",   bus.owner,       0);
        chk("rst_radio",   bus.radio_rx_en, 0);
        chk("rst_rxwin",   bus.rx_window,   0);
        chk("rst_done",    bus.done,        0);
        chk("rst_aborted", bus.aborted,     0);
        chk("rst_busy",    bus.busy,        0);
    endtask

    task automatic do_reset();
        arst = 1'b1;
        repeat (2) @(negedge ck);
        chk_outs_zero();
        @(posedge ck);
        #1 arst = 1'b0;
    endtask

    task automatic wait_gnt(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge ck);
            if (bus.gnt != '0) seen = 1'b1;
        end
        chk("gnt_seen", seen, 1);
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        do begin
            @(negedge ck);
            i++;
        end while ((sb.size() != 0 || in_win || bus.busy) && i < budget);
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        bit  seen;
        arst      = 1'b1;
        bus.req   = '0;
        bus.len   = '0;
        bus.abort = 1'b0;
        fork
            monitor();
        join_none

        // Single request, len 5: grant exactly one cycle after sampling.
        do_reset();
        set_len(0, 5);
        bus.req = 4'b0001;
        sb.push_back(mk(0, 5, 0, -1));
        @(negedge ck);
        chk("gnt_early", bus.gnt, 0);
        @(negedge ck);
        chk("gnt_latency", bus.gnt, 4'b0001);
        bus.req = '0;
        wait_idle(60);

        // Round-robin with all four requesting, len 1: 0,1,2,3,0 every 8 cycles.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_len(i, 1);
        sb.push_back(mk(0, 1, 0, -1));
        sb.push_back(mk(1, 1, 0, 8));
        sb.push_back(mk(2, 1, 0, 8));
        sb.push_back(mk(3, 1, 0, 8));
        sb.push_back(mk(0, 1, 0, 8));
        bus.req = 4'b1111;
        cnt = 0;
        for (int i = 0; i < 80 && cnt < 5; i++) begin
            @(negedge ck);
            if (bus.gnt != '0) cnt++;
        end
        bus.req = '0;
        chk("rr_grants", cnt, 5);
        wait_idle(60);

        // Zero-length window for requester 2 (rr_ptr now 1).
        set_len(2, 0);
        bus.req = 4'b0100;
        sb.push_back(mk(2, 0, 0, -1));
        wait_gnt(20);
        bus.req = '0;
        wait_idle(60);

        // Abort on the 2nd ACTIVE cycle of a len 10 window (requester 3).
        set_len(3, 10);
        bus.req = 4'b1000;
        sb.push_back(mk(3, 10, 6, -1));
        wait_gnt(20);
        bus.req = '0;
        repeat (5) @(posedge ck);
        #1 bus.abort = 1'b1;
        @(posedge ck);
        #1 bus.abort = 1'b0;
        @(negedge ck);
        chk("abort_radio", bus.radio_rx_en, 0);
        chk("abort_done", bus.done, 1);
        chk("abort_flag", bus.aborted, 1);
        wait_idle(60);

        // Withdrawal and len sampling: len0 changed after grant, req[2] pulsed mid-window.
        set_len(0, 6);
        bus.req = 4'b0001;
        sb.push_back(mk(0, 6, 0, -1));
        wait_gnt(20);
        bus.req = '0;
        set_len(0, 1);
        @(negedge ck);
        bus.req = 4'b0100;
        repeat (3) @(negedge ck);
        bus.req = '0;
        wait_idle(60);
        cnt = 0;
        repeat (20) begin
            @(negedge ck);
            if (bus.gnt != '0) cnt++;
        end
        chk("withdrawn_gnt", cnt, 0);

        // Reset in ACTIVE: outputs clear at once, no done, rr_ptr back to 0.
        set_len(1, 10);
        bus.req = 4'b0010;
        wait_gnt(20);
        bus.req = '0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.rx_window) seen = 1'b1;
            else @(negedge ck);
        end
        chk("rxw_seen", seen, 1);
        #2 arst = 1'b1;
        #1 chk_outs_zero();
        cnt = 0;
        repeat (3) begin
            @(negedge ck);
            if (bus.done) cnt++;
        end
        chk("rst_no_done", cnt, 0);
        @(posedge ck);
        #1 arst = 1'b0;
        set_len(0, 3);
        set_len(3, 3);
        bus.req = 4'b1001;
        sb.push_back(mk(0, 3, 0, -1));
        wait_gnt(20);
        chk("owner_after_rst", bus.owner, 0);
        bus.req = '0;
        wait_idle(60);

        chk("sb_left", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/rx_window_sched.md
# rx_window_sched

Radio receive-window scheduler for the timing engine. It arbitrates round-robin among NREQ requesters that each want one receive window of a programmable length. For the winner it sequences the radio receive enable through warm-up, active and guard phases. Its `radio_rx_en` output is the raw enable that the timing-engine synchronizer turns into `radioRxEnSynced`, which then drives the registered `radioRxEn`.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `LW`, default 8: width of each window-length field.
- `WARMUP_CYC`, default 4: cycles of radio warm-up before data is valid (>=1).
- `GUARD_CYC`, default 2: cycles the radio is held off after a window (>=1).

Ports:
- `ck`  in  1: clock, all logic on posedge.
- `arst`  in  1: reset. Asynchronous, active-high.
- `req`  in  NREQ: per-requester window request, level, held until `gnt`.
- `len`  in  NREQ*LW: per-requester window length in cycles. Field i is `len[i*LW +: LW]`.
- `abort`  in  1: terminate the current window early.
- `gnt`  out  NREQ: one-hot, one-cycle grant pulse.
- `owner`  out  $clog2(NREQ): index of the current or last granted requester.
- `radio_rx_en`  out  1: raw radio receive enable (to the synchronizer).
- `rx_window`  out  1: high while received data is valid.
- `done`  out  1: one-cycle end-of-window pulse.
- `aborted`  out  1: qualifies `done`; high if the window ended by `abort`.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, WARMUP, ACTIVE, GUARD. All outputs are registered.
- IDLE:
  - If `req != 0`, select the first set bit scanning upward from `rr_ptr` with wrap-around.
  - Latch the winner's `len` and set `owner`.
  - Set `rr_ptr = winner+1` (mod NREQ) and go to WARMUP.
- WARMUP:
  - `radio_rx_en=1`, `rx_window=0`, `gnt[owner]=1` in the first WARMUP cycle only.
  - Leave after WARMUP_CYC cycles: to ACTIVE if latched len>0, else to GUARD.
- ACTIVE: `radio_rx_en=1`, `rx_window=1`. Leave to GUARD after latched len cycles.
- GUARD:
  - `radio_rx_en=0`, `rx_window=0`.
  - `done=1` in the first GUARD cycle; `aborted` is valid with it.
  - Leave to IDLE after GUARD_CYC cycles.
- `abort` sampled high in WARMUP or ACTIVE: next cycle is GUARD with `done=1` and `aborted=1`. `abort` is ignored in IDLE and GUARD.
- A requester dropping `req` before its `gnt` withdraws the request with no side effects. `req` changes after `gnt` are ignored until the FSM returns to IDLE.
- `len` is sampled only in the IDLE cycle that makes the decision. Later changes do not affect the current window.
- Counter width is max(LW, $clog2(max(WARMUP_CYC, GUARD_CYC))+1). The counter is loaded on state entry and counts down. There is no wrap: len=2^LW-1 gives exactly 2^LW-1 ACTIVE cycles.

Reset (`arst` asserted, any time including mid-window):
- State=IDLE, `rr_ptr=0`, `owner=0`, `gnt=0`, `radio_rx_en=0`, `rx_window=0`, `done=0`, `aborted=0`, `busy=0`.
- No `done` is generated for a window killed by reset.
- The first IDLE evaluation happens on the first posedge after `arst` deasserts.

## Timing
- Latency: `req` sampled in IDLE at edge t gives `gnt` and `radio_rx_en` high in cycle t+1.
- `radio_rx_en` is high for WARMUP_CYC+len cycles. `rx_window` is high for the last len of them.
- `done` fires in the cycle immediately after the last `radio_rx_en` cycle.
- Minimum spacing between consecutive `gnt` pulses is WARMUP_CYC+len+GUARD_CYC+1 cycles (at least one IDLE cycle).
- Abort in cycle k (WARMUP/ACTIVE): `radio_rx_en=0` and `done=1` in cycle k+1.
- `busy` is high from the first WARMUP cycle through the last GUARD cycle.

## Test plan
- **Single request.** Reset, then `req=0001` with len0=5 (defaults). Expect:
  - `gnt=0001` one cycle after the request is sampled.
  - `radio_rx_en` high 9 cycles, `rx_window` high cycles 5..9.
  - `done=1`, `aborted=0` in cycle 10.
  - `busy` low after 2 GUARD cycles.
- **Round-robin.** Hold `req=1111` with all len=1. Expect:
  - Grants in order 0,1,2,3,0.
  - Successive `gnt` pulses exactly 8 cycles apart.
- **Zero length.** len=0. Expect `radio_rx_en` high 4 cycles, `rx_window` never high, `done` in cycle 5.
- **Abort.** Assert `abort` on the 2nd ACTIVE cycle of a len=10 window. Expect `radio_rx_en` low and `done=1`, `aborted=1` the next cycle; GUARD still lasts 2 cycles.
- **Withdrawal and len sampling.**
  - `req[2]` pulsed during another window and dropped before IDLE: no grant to requester 2.
  - len changed after `gnt`: the window length is unchanged.
- **Reset mid-window.** Assert `arst` during ACTIVE. Expect all outputs 0 immediately, no `done`, and the next grant is to the lowest set `req` bit (`rr_ptr=0`).
